cache_coh_ctrl: RTL
===================

CACHE_COH_CTRL -- requirements
Module: cache_coh_ctrl

Interface
REQ-001 SHALL have parameter LINES, default 8, number of direct-mapped lines (power of 2).
REQ-002 SHALL have parameter DW, default 16, data word width.
REQ-003 SHALL have ports as follows, clock and reset first:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_rd  in  1  CPU load request.
- cpu_wr  in  1  CPU store request.
- cpu_addr  in  11  CPU word address.
- cpu_wdata  in  DW  store data.
- cpu_rdata  out  DW  load data, valid when cpu_rd && !cpu_stall.
- cpu_stall  out  1  CPU must hold its request.
- read_miss  out  1  read-miss request to bus.
- write_miss  out  1  write-miss request to bus.
- invalidate  out  1  upgrade S->M request to bus.
- block_state  out  2  state of the indexed line: 00=M, 01=S, 10=I.
- miss_addr  out  11  address of the pending bus request.
- grant  in  1  bus grants this CPU.
- datasel  in  1  fill source: 1=other CPU, 0=dmem.
- fill_data  in  DW  fill word.
- fill_valid  in  1  fill_data valid this cycle.
- wback_dmem  out  1  one-cycle pulse: write the line at miss_addr to dmem.
- wback_data  out  DW  data for wback_dmem.
- snoop_addr  in  11  bus address for snoop and invalidate.
- search  in  1  snoop lookup request.
- search_found  out  1  combinational: search && tag hit && state!=I.
- snoop_data  out  DW  data of the snooped line.
- invalidate_tag  in  1  invalidate the line matching snoop_addr.

Function
REQ-004 SHALL split the address as index = addr[log2(LINES)-1:0] and tag = remaining upper bits; each line holds tag, state[1:0] and one DW word.
REQ-005 SHALL use the FSM states IDLE, REQ_RD, FILL, REQ_WR and REQ_UPG.
REQ-006 IDLE with read hit (tag match, state M or S): SHALL drive cpu_rdata combinationally, with cpu_stall=0.
REQ-007 IDLE with a write hit on an M line: SHALL write the data at the next edge, with cpu_stall=0.
REQ-008 IDLE with a write hit on an S line: SHALL go to REQ_UPG with cpu_stall=1.
REQ-009 IDLE with a read miss (tag mismatch or I): SHALL go to REQ_RD.
REQ-010 IDLE with a write miss: SHALL go to REQ_WR.
REQ-011 cpu_rd and cpu_wr both high: SHALL give the write priority.
REQ-012 REQ_RD: SHALL hold read_miss=1 and miss_addr=cpu_addr until grant=1, then go to FILL.
REQ-013 FILL: on fill_valid, SHALL write tag, fill_data and state S, and return to IDLE; cpu_stall drops in the cycle after the fill.
REQ-014 REQ_WR: SHALL hold write_miss=1 until grant.
REQ-015 On grant in REQ_WR: SHALL write tag, cpu_wdata and state M, pulse wback_dmem with wback_data=cpu_wdata, and return to IDLE.
REQ-016 REQ_UPG: SHALL hold invalidate=1 until grant.
REQ-017 On grant in REQ_UPG: SHALL set the line to M, write the data, pulse wback_dmem, and return to IDLE.
REQ-018 cpu_stall SHALL be 1 in every state except IDLE-hit; read_miss, write_miss and invalidate SHALL be mutually exclusive.
REQ-019 Snoop search hit on an M line: SHALL downgrade it to S at the next edge; an S line is unchanged; snoop_data is always the indexed line's word.
REQ-020 invalidate_tag with a tag hit: SHALL set the line to I at the next edge.
REQ-021 invalidate_tag that hits the line of a pending REQ_UPG (before grant): SHALL drop invalidate and move to REQ_WR (now a write miss).
REQ-022 Snoop on an index equal to a FILL-in-progress line: SHALL return search_found=0 for it until the fill completes.
REQ-023 A snoop state update and a local update to the same line in the same cycle: the local (granted) update SHALL win.
REQ-024 block_state SHALL report the indexed line's state for miss_addr while a request is pending, otherwise for cpu_addr.

Reset
REQ-025 rst=1 at an edge: SHALL set every line to I, FSM to IDLE, and all outputs to 0 except block_state=10.
REQ-026 Reset mid-request: SHALL abandon it with no wback_dmem pulse.

Verification
REQ-027 Directed scenarios:
- Reset, then cpu_rd addr 0x005 -> read_miss=1, miss_addr=0x005; grant, then fill_valid data 0xBEEF -> line 5 is S; next read returns 0xBEEF with no stall.
- cpu_wr 0x005 data 0x1234 on the S line -> invalidate=1; grant -> state M, one wback_dmem pulse with 0x1234.
- Line M, search at 0x005 -> search_found=1 and snoop_data=0x1234 the same cycle; next cycle block_state=01.
- Pending REQ_UPG, invalidate_tag at 0x005 -> invalidate drops and write_miss=1 next cycle.
- cpu_wr 0x00D (same index, other tag) -> write_miss; grant -> tag replaced, state M.
- rst during FILL -> all lines I, cpu_stall=0, no fill written.

Source files
------------

// File: rtl/cache_coh_ctrl.sv
// Direct-mapped, single-word-per-line cache controller with MSI-style coherence.
// One CPU port, one bus request port, and a snoop/invalidate port.
module cache_coh_ctrl #(
    parameter int unsigned LINES = 8,
    parameter int unsigned DW    = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_rd,
    input  logic          cpu_wr,
    input  logic [10:0]   cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    output logic          read_miss,
    output logic          write_miss,
    output logic          invalidate,
    output logic [1:0]    block_state,
    output logic [10:0]   miss_addr,
    input  logic          grant,
    input  logic          datasel,
    input  logic [DW-1:0] fill_data,
    input  logic          fill_valid,
    output logic          wback_dmem,
    output logic [DW-1:0] wback_data,
    input  logic [10:0]   snoop_addr,
    input  logic          search,
    output logic          search_found,
    output logic [DW-1:0] snoop_data,
    input  logic          invalidate_tag
);

    localparam int unsigned IW = $clog2(LINES);
    localparam int unsigned TW = 11 - IW;

    localparam logic [1:0] LineM = 2'b00;
    localparam logic [1:0] LineS = 2'b01;
    localparam logic [1:0] LineI = 2'b10;

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StReqRd  = 3'd1;
    localparam logic [2:0] StFill   = 3'd2;
    localparam logic [2:0] StReqWr  = 3'd3;
    localparam logic [2:0] StReqUpg = 3'd4;

    logic [TW-1:0] tag_q  [LINES];
    logic [1:0]    st_q   [LINES];
    logic [DW-1:0] data_q [LINES];

    logic [2:0]    fsm_q, fsm_d;
    logic [10:0]   req_addr_q;
    logic          wback_q, wback_d;
    logic [DW-1:0] wback_data_q;

    logic [IW-1:0] cpu_idx, snp_idx, req_idx;
    logic [TW-1:0] cpu_tag, snp_tag, req_tag;
    logic          cpu_hit, snp_hit, fill_block, inv_hit, rd_req, idle_done;

    logic          loc_we;
    logic [IW-1:0] loc_idx;
    logic [TW-1:0] loc_tag;
    logic [1:0]    loc_st;
    logic [DW-1:0] loc_data;

    assign cpu_idx = cpu_addr[IW-1:0];
    assign cpu_tag = cpu_addr[10:IW];
    assign snp_idx = snoop_addr[IW-1:0];
    assign snp_tag = snoop_addr[10:IW];
    assign req_idx = req_addr_q[IW-1:0];
    assign req_tag = req_addr_q[10:IW];

    assign rd_req     = cpu_rd && !cpu_wr;
    assign cpu_hit    = (tag_q[cpu_idx] == cpu_tag) && (st_q[cpu_idx] != LineI);
    assign snp_hit    = (tag_q[snp_idx] == snp_tag) && (st_q[snp_idx] != LineI);
    // A line being refilled is invisible to snoops until the fill lands.
    assign fill_block = (fsm_q == StFill) && (snp_idx == req_idx);
    assign inv_hit    = invalidate_tag && snp_hit;

    // The only IDLE cases that complete without a bus transaction.
    assign idle_done = (cpu_wr && cpu_hit && st_q[cpu_idx] == LineM) ||
                       (rd_req && cpu_hit) || (!cpu_wr && !cpu_rd);

    always_comb begin
        fsm_d    = fsm_q;
        loc_we   = 1'b0;
        loc_idx  = req_idx;
        loc_tag  = req_tag;
        loc_st   = LineM;
        loc_data = cpu_wdata;
        wback_d  = 1'b0;
        case (fsm_q)
            StIdle: begin
                if (cpu_wr) begin
                    if (cpu_hit && st_q[cpu_idx] == LineM) begin
                        loc_we  = 1'b1;
                        loc_idx = cpu_idx;
                        loc_tag = cpu_tag;
                    end else if (cpu_hit) begin
                        fsm_d = StReqUpg;
                    end else begin
                        fsm_d = StReqWr;
                    end
                end else if (cpu_rd && !cpu_hit) begin
                    fsm_d = StReqRd;
                end
            end
            StReqRd: if (grant) fsm_d = StFill;
            StFill: begin
                if (fill_valid) begin
                    loc_we   = 1'b1;
                    loc_st   = LineS;
                    loc_data = fill_data;
                    fsm_d    = StIdle;
                end
            end
            StReqWr, StReqUpg: begin
                if (grant) begin
                    loc_we  = 1'b1;
                    wback_d = 1'b1;
                    fsm_d   = StIdle;
                end else if (fsm_q == StReqUpg && inv_hit && snp_idx == req_idx) begin
                    // Our shared copy was taken away: the upgrade becomes a full write miss.
                    fsm_d = StReqWr;
                end
            end
            default: fsm_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q        <= StIdle;
            req_addr_q   <= '0;
            wback_q      <= 1'b0;
            wback_data_q <= '0;
            for (int i = 0; i < LINES; i++) begin
                tag_q[i]  <= '0;
                st_q[i]   <= LineI;
                data_q[i] <= '0;
            end
        end else begin
            fsm_q   <= fsm_d;
            wback_q <= wback_d;
            if (fsm_q == StIdle) req_addr_q <= cpu_addr;
            if (wback_d) wback_data_q <= cpu_wdata;
            if (inv_hit) begin
                st_q[snp_idx] <= LineI;
            end else if (search_found && st_q[snp_idx] == LineM) begin
                st_q[snp_idx] <= LineS;
            end
            // Issued after the snoop update so a local write to the same line wins.
            if (loc_we) begin
                tag_q[loc_idx]  <= loc_tag;
                st_q[loc_idx]   <= loc_st;
                data_q[loc_idx] <= loc_data;
            end
        end
    end

    assign search_found = search && snp_hit && !fill_block;
    assign snoop_data   = data_q[snp_idx];
    assign cpu_stall    = !((fsm_q == StIdle) && idle_done);
    assign cpu_rdata    = (fsm_q == StIdle && rd_req && cpu_hit) ? data_q[cpu_idx] : '0;
    assign read_miss    = (fsm_q == StReqRd);
    assign write_miss   = (fsm_q == StReqWr);
    assign invalidate   = (fsm_q == StReqUpg);
    assign miss_addr    = (fsm_q != StIdle) ? req_addr_q : '0;
    assign block_state  = (fsm_q != StIdle) ? st_q[req_idx] : st_q[cpu_idx];
    assign wback_dmem   = wback_q;
    assign wback_data   = wback_data_q;

    // Fill source selection happens on the bus side; the word arrives already muxed.
    logic unused_datasel;
    assign unused_datasel = datasel;

endmodule
